// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler: per-slot second match, lowest-index arbitration, shared melody enable.
// Latency: ring starts 1 clk after the pending flag sets; no backpressure, writes/buttons are 1-cycle pulses.
module alarm_scheduler #(
    parameter  int SLOTS  = 4,
    parameter  int SEC_W  = 17,
    parameter  int LEN_W  = 6,
    parameter  int SNOOZE = 300,
    parameter  int DAY    = 86400,
    localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_onehz,
    input  logic [SEC_W-1:0] i_cur_sec,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_slot,
    input  logic [SEC_W-1:0] i_wr_sec,
    input  logic [LEN_W-1:0] i_wr_len,
    input  logic             i_wr_on,
    input  logic             i_btn_dismiss,
    input  logic             i_btn_snooze,
    output logic             o_sound,
    output logic             o_ringing,
    output logic [IDX_W-1:0] o_active_slot,
    output logic [SLOTS-1:0] o_pending
);

    typedef enum logic {ST_IDLE, ST_RING} state_t;

    localparam logic [SEC_W:0] DAY_V    = (SEC_W+1)'(DAY);
    localparam logic [SEC_W:0] SNOOZE_V = (SEC_W+1)'(SNOOZE);

    logic             r_sync1, r_sync2, r_sync3;
    logic             w_tick;
    logic [SLOTS-1:0] r_on;
    logic [SEC_W-1:0] r_sec [SLOTS];
    logic [LEN_W-1:0] r_len [SLOTS];
    logic [SLOTS-1:0] r_pending;
    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_active, w_active_nxt;
    logic [LEN_W-1:0] r_remaining, w_rem_nxt;
    logic [SLOTS-1:0] w_match, w_fsm_clr, w_wr_clr;
    logic [IDX_W-1:0] w_sel;
    logic             w_wr_ok, w_wr_abort, w_snooze;
    logic [SEC_W:0]   w_snz_sum;
    logic [SEC_W-1:0] w_snz_sec;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_onehz;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_tick  = r_sync2 & ~r_sync3;
    assign w_wr_ok = i_wr_en && ({1'b0, i_wr_sec} < DAY_V);
    assign w_wr_clr = w_wr_ok ? (SLOTS'(1) << i_wr_slot) : '0;
    assign w_wr_abort = w_wr_ok && (r_state == ST_RING) && (i_wr_slot == r_active);

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            w_match[i] = w_tick && r_on[i] && (r_len[i] != '0) && (r_sec[i] == i_cur_sec);
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (r_pending[i]) w_sel = IDX_W'(i);
        end
    end

    // Sum is one bit wider than SEC_W so the wrap test cannot overflow.
    assign w_snz_sum = {1'b0, i_cur_sec} + SNOOZE_V;
    assign w_snz_sec = (w_snz_sum >= DAY_V) ? SEC_W'(w_snz_sum - DAY_V) : w_snz_sum[SEC_W-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_rem_nxt    = r_remaining;
        w_fsm_clr    = '0;
        w_snooze     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Hold off one cycle if the chosen slot is being rewritten right now.
                if ((r_pending != '0) && !(w_wr_ok && (i_wr_slot == w_sel))) begin
                    w_state_nxt  = ST_RING;
                    w_active_nxt = w_sel;
                    w_rem_nxt    = r_len[w_sel];
                end
            end
            ST_RING: begin
                if (w_wr_abort) begin
                    w_state_nxt  = ST_IDLE;
                    w_active_nxt = '0;
                end else if (i_btn_dismiss) begin
                    w_fsm_clr    = SLOTS'(1) << r_active;
                    w_state_nxt  = ST_IDLE;
                    w_active_nxt = '0;
                end else if (i_btn_snooze) begin
                    w_fsm_clr    = SLOTS'(1) << r_active;
                    w_snooze     = 1'b1;
                    w_state_nxt  = ST_IDLE;
                    w_active_nxt = '0;
                end else if (w_tick) begin
                    if (r_remaining <= LEN_W'(1)) begin
                        w_fsm_clr    = SLOTS'(1) << r_active;
                        w_rem_nxt    = '0;
                        w_state_nxt  = ST_IDLE;
                        w_active_nxt = '0;
                    end else begin
                        w_rem_nxt = r_remaining - LEN_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_active_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_active    <= '0;
            r_remaining <= '0;
            r_pending   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_active    <= w_active_nxt;
            r_remaining <= w_rem_nxt;
            r_pending   <= (r_pending | w_match) & ~w_fsm_clr & ~w_wr_clr;
        end
    end

    // A write issued in the same cycle as a snooze on that slot takes precedence.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_on <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_sec[i] <= '0;
                r_len[i] <= '0;
            end
        end else begin
            if (w_snooze) r_sec[r_active] <= w_snz_sec;
            if (w_wr_ok) begin
                r_on[i_wr_slot]  <= i_wr_on;
                r_sec[i_wr_slot] <= i_wr_sec;
                r_len[i_wr_slot] <= i_wr_len;
            end
        end
    end

    assign o_sound       = (r_state == ST_RING);
    assign o_ringing     = (r_state == ST_RING);
    assign o_active_slot = r_active;
    assign o_pending     = r_pending;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler: per-second stimulus table with a scoreboard queue,
// plus hand sequences for power-on and asynchronous mid-ring reset.
module tb_alarm_scheduler;

    localparam int SLOTS = 4;
    localparam int SEC_W = 17;
    localparam int LEN_W = 6;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_onehz = 1'b0;
    logic [SEC_W-1:0] i_cur_sec = '0;
    logic             i_wr_en = 1'b0;
    logic [1:0]       i_wr_slot = '0;
    logic [SEC_W-1:0] i_wr_sec = '0;
    logic [LEN_W-1:0] i_wr_len = '0;
    logic             i_wr_on = 1'b0;
    logic             i_btn_dismiss = 1'b0;
    logic             i_btn_snooze = 1'b0;
    logic             o_sound;
    logic             o_ringing;
    logic [1:0]       o_active_slot;
    logic [SLOTS-1:0] o_pending;

    alarm_scheduler #(.SLOTS(SLOTS), .SEC_W(SEC_W), .LEN_W(LEN_W), .SNOOZE(300), .DAY(86400)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_onehz(i_onehz), .i_cur_sec(i_cur_sec),
        .i_wr_en(i_wr_en), .i_wr_slot(i_wr_slot), .i_wr_sec(i_wr_sec), .i_wr_len(i_wr_len),
        .i_wr_on(i_wr_on), .i_btn_dismiss(i_btn_dismiss), .i_btn_snooze(i_btn_snooze),
        .o_sound(o_sound), .o_ringing(o_ringing), .o_active_slot(o_active_slot), .o_pending(o_pending)
    );

    always #5 i_clk = ~i_clk;

    typedef enum int {A_NONE, A_WR, A_WRT, A_DIS, A_SNZ, A_BOTH} act_e;

    // trace bit i = o_sound at the falling edge after the (i+1)-th rising clk edge following the onehz rise
    typedef struct {
        int         sec;
        act_e       act;
        int         ws;
        int         wsec;
        int         wlen;
        bit         won;
        logic [7:0] trace;
        logic       after;
        int         active;
        logic [3:0] pend;
    } vec_t;

    typedef struct {
        logic [7:0] trace;
        logic       after;
        logic [1:0] active;
        logic [3:0] pend;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[27];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(int sec, act_e act, int ws, int wsec, int wlen, bit won,
                                logic [7:0] trace, logic after, int active, logic [3:0] pend);
        vec_t v;
        v.sec = sec; v.act = act; v.ws = ws; v.wsec = wsec; v.wlen = wlen; v.won = won;
        v.trace = trace; v.after = after; v.active = active; v.pend = pend;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_wr(input vec_t v);
        i_wr_en   = 1'b1;
        i_wr_slot = 2'(v.ws);
        i_wr_sec  = SEC_W'(v.wsec);
        i_wr_len  = LEN_W'(v.wlen);
        i_wr_on   = v.won;
    endtask

    task automatic run_step(input int idx, input vec_t v);
        exp_t       e;
        exp_t       got;
        logic [7:0] tr;
        e.trace = v.trace; e.after = v.after; e.active = 2'(v.active); e.pend = v.pend;
        sb.push_back(e);
        @(negedge i_clk);
        i_onehz   = 1'b1;
        i_cur_sec = SEC_W'(v.sec);
        tr = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            tr[i] = o_sound;
            if (v.act == A_WRT && i == 1) drive_wr(v);
            if (v.act == A_WRT && i == 2) i_wr_en = 1'b0;
        end
        got = sb.pop_front();
        check($sformatf("step%0d sec%0d sound_trace", idx, v.sec), {24'd0, tr}, {24'd0, got.trace});
        check($sformatf("step%0d sec%0d ringing", idx, v.sec), {31'd0, o_ringing}, {31'd0, got.trace[7]});
        check($sformatf("step%0d sec%0d active_slot", idx, v.sec), {30'd0, o_active_slot}, {30'd0, got.active});
        check($sformatf("step%0d sec%0d pending", idx, v.sec), {28'd0, o_pending}, {28'd0, got.pend});
        i_onehz = 1'b0;
        case (v.act)
            A_WR:    drive_wr(v);
            A_DIS:   i_btn_dismiss = 1'b1;
            A_SNZ:   i_btn_snooze = 1'b1;
            A_BOTH:  begin i_btn_dismiss = 1'b1; i_btn_snooze = 1'b1; end
            default: ;
        endcase
        @(negedge i_clk);
        i_wr_en = 1'b0; i_btn_dismiss = 1'b0; i_btn_snooze = 1'b0;
        check($sformatf("step%0d sec%0d sound_after_action", idx, v.sec), {31'd0, o_sound}, {31'd0, got.after});
        @(negedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(0,     A_WR,   0, 10,    3,  1, 8'h00, 1'b0, 0, 4'b0000);
        tbl[1]  = mk(9,     A_NONE, 0, 0,     0,  0, 8'h00, 1'b0, 0, 4'b0000);
        tbl[2]  = mk(10,    A_NONE, 0, 0,     0,  0, 8'hF8, 1'b1, 0, 4'b0001);
        tbl[3]  = mk(11,    A_NONE, 0, 0,     0,  0, 8'hFF, 1'b1, 0, 4'b0001);
        tbl[4]  = mk(12,    A_NONE, 0, 0,     0,  0, 8'hFF, 1'b1, 0, 4'b0001);
        tbl[5]  = mk(13,    A_WR,   1, 50,    2,  1, 8'h03, 1'b0, 0, 4'b0000);
        tbl[6]  = mk(14,    A_WR,   2, 50,    2,  1, 8'h00, 1'b0, 0, 4'b0000);
        tbl[7]  = mk(50,    A_NONE, 0, 0,     0,  0, 8'hF8, 1'b1, 1, 4'b0110);
        tbl[8]  = mk(51,    A_NONE, 0, 0,     0,  0, 8'hFF, 1'b1, 1, 4'b0110);
        tbl[9]  = mk(52,    A_NONE, 0, 0,     0,  0, 8'hFB, 1'b1, 2, 4'b0100);
        tbl[10] = mk(53,    A_NONE, 0, 0,     0,  0, 8'hFF, 1'b1, 2, 4'b0100);
        tbl[11] = mk(54,    A_WR,   0, 86300, 60, 1, 8'h03, 1'b0, 0, 4'b0000);
        tbl[12] = mk(86300, A_NONE, 0, 0,     0,  0, 8'hF8, 1'b1, 0, 4'b0001);
        tbl[13] = mk(86305, A_SNZ,  0, 0,     0,  0, 8'hFF, 1'b0, 0, 4'b0001);
        tbl[14] = mk(86306, A_WR,   3, 100,   0,  1, 8'h00, 1'b0, 0, 4'b0000);
        tbl[15] = mk(100,   A_NONE, 0, 0,     0,  0, 8'h00, 1'b0, 0, 4'b0000);
        tbl[16] = mk(86300, A_NONE, 0, 0,     0,  0, 8'h00, 1'b0, 0, 4'b0000);
        tbl[17] = mk(205,   A_NONE, 0, 0,     0,  0, 8'hF8, 1'b1, 0, 4'b0001);
        tbl[18] = mk(206,   A_BOTH, 0, 0,     0,  0, 8'hFF, 1'b0, 0, 4'b0001);
        tbl[19] = mk(207,   A_NONE, 0, 0,     0,  0, 8'h00, 1'b0, 0, 4'b0000);
        tbl[20] = mk(205,   A_NONE, 0, 0,     0,  0, 8'hF8, 1'b1, 0, 4'b0001);
        tbl[21] = mk(206,   A_WR,   0, 7,     3,  1, 8'hFF, 1'b0, 0, 4'b0001);
        tbl[22] = mk(207,   A_DIS,  0, 0,     0,  0, 8'h00, 1'b0, 0, 4'b0000);
        tbl[23] = mk(205,   A_WR,   0, 90000, 3,  1, 8'h00, 1'b0, 0, 4'b0000);
        tbl[24] = mk(7,     A_WR,   0, 7,     3,  1, 8'hF8, 1'b0, 0, 4'b0001);
        tbl[25] = mk(7,     A_WRT,  0, 7,     3,  1, 8'h00, 1'b0, 0, 4'b0000);
        tbl[26] = mk(7,     A_NONE, 0, 0,     0,  0, 8'hF8, 1'b1, 0, 4'b0001);

        #12;
        check("reset sound", {31'd0, o_sound}, 32'd0);
        check("reset ringing", {31'd0, o_ringing}, 32'd0);
        check("reset active_slot", {30'd0, o_active_slot}, 32'd0);
        check("reset pending", {28'd0, o_pending}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);

        for (int k = 0; k < 27; k++) run_step(k, tbl[k]);

        // Slot0 is ringing here; pull reset between clock edges.
        @(posedge i_clk);
        #3 i_rst = 1'b0;
        #1;
        check("async reset sound", {31'd0, o_sound}, 32'd0);
        check("async reset ringing", {31'd0, o_ringing}, 32'd0);
        check("async reset pending", {28'd0, o_pending}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        run_step(27, mk(7, A_NONE, 0, 0, 0, 0, 8'h00, 1'b0, 0, 4'b0000));
        run_step(28, mk(0, A_NONE, 0, 0, 0, 0, 8'h00, 1'b0, 0, 4'b0000));

        check("scoreboard drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
Multi-slot alarm controller for the digital clock. Holds SLOTS programmable alarms, compares each against the running second count once per second, and sequences one shared melody player (`sound` enable). Arbitrates simultaneous alarms, counts ring length, and handles dismiss/snooze buttons. Sits between the seconds counter / 1 Hz generator and the melody player, replacing the single fixed-target alarm.

Parameters:
SLOTS, 4, number of alarm slots (2..8)
SEC_W, 17, width of second-of-day values
LEN_W, 6, width of ring length in seconds
SNOOZE, 300, snooze delay in seconds
DAY, 86400, seconds per day (wrap modulus)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
onehz  in  1  1 Hz square wave from the 1 Hz generator, asynchronous to the scheduler
cur_sec  in  SEC_W  current second of day, 0..DAY-1, updates on onehz rising edge
wr_en  in  1  one-cycle pulse: program slot wr_slot
wr_slot  in  clog2(SLOTS)  slot index for write
wr_sec  in  SEC_W  target second (values >= DAY are ignored: write dropped)
wr_len  in  LEN_W  ring length in seconds
wr_on  in  1  slot enable
btn_dismiss  in  1  one-cycle pulse, debounced upstream
btn_snooze  in  1  one-cycle pulse, debounced upstream
sound  out  1  melody player enable
ringing  out  1  FSM in RING
active_slot  out  clog2(SLOTS)  slot currently ringing (0 when idle)
pending  out  SLOTS  per-slot triggered-not-served flags

Behaviour:
- Reset (rst=0, async): all slots on=0, sec=0, len=0; pending=0; FSM IDLE; sound=0, ringing=0, active_slot=0; tick sync regs=0.
- Tick: onehz passes through a 2-FF synchronizer. A third register detects the rising edge and produces `tick`, a 1-cycle pulse 3 clk after the onehz edge. cur_sec is sampled on the tick cycle; it is stable by then.
- Match: on tick, for each slot with on=1, len!=0 and sec==cur_sec, set pending[i]. A slot with len=0 never triggers.
- Write: on wr_en with a valid wr_sec, slot fields update next cycle and pending[wr_slot] clears.
  - Writing the active slot while in RING aborts the ring: RING->IDLE, sound=0 next cycle.
  - If wr_en and tick hit the same cycle on the same slot, the write wins: no pending set.
- FSM IDLE:
  - If pending!=0, select the lowest-index pending slot and go to RING next cycle.
  - Load remaining=len of that slot and set active_slot.
  - sound=1, ringing=1 from the RING entry cycle.
- FSM RING:
  - Each tick decrements remaining. At remaining 1->0, clear pending[active], go IDLE, sound=0.
  - btn_dismiss: clear pending[active], go IDLE next cycle. The slot stays enabled and rings again the next day.
  - btn_snooze: slot sec <= (cur_sec+SNOOZE) mod DAY, clear pending[active], go IDLE. Wrap example: 86300+300 -> 200.
  - Both buttons in the same cycle: dismiss wins.
  - Buttons in IDLE are ignored.
  - Tick and button in the same cycle: the button wins, no decrement.
- Back-to-back: other slots that become pending during RING stay pending. After return to IDLE, the next one starts 1 cycle later (one IDLE cycle, sound=0 for that cycle).
- Re-trigger: a slot already pending or ringing that matches again is not duplicated; pending is a flag, not a count.
- Arithmetic:
  - The snooze sum is computed at SEC_W+1 bits, then reduced by a conditional subtract of DAY.
  - remaining is LEN_W bits with no underflow.
- Outputs are registered; no combinational path from inputs to sound.

Test Plan:
1. Reset, program slot0 sec=10 len=3 on=1, step cur_sec 0..20 with onehz -> sound rises 1 cycle after the cur_sec=10 tick, falls on the cur_sec=13 tick; pending[0] is 0 afterwards; active_slot=0.
2. Slots 1 and 2 both at sec=50 len=2 -> slot1 rings for 2 s, then 1 IDLE cycle with sound=0, then slot2 rings for 2 s; pending=3'b110 during the first ring.
3. Slot0 sec=86300 len=60 rings; btn_snooze at cur_sec=86305 -> sound=0 next cycle, slot0 sec reads 205, rings again at cur_sec=205.
4. btn_dismiss and btn_snooze in the same cycle during a ring -> IDLE, slot sec unchanged; the slot rings at the same second on the next day wrap.
5. During slot0 ring, wr_en to slot0 with sec=7 -> ring aborts next cycle; also check that wr_en coincident with a matching tick sets no pending.
6. Assert rst low mid-ring, asynchronous to clk -> sound, ringing and pending drop immediately; the slot stays disabled after release.
